// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: state encoding
// and the default operand width.
package serial_add_ctrl_pkg;

  localparam int DEF_WIDTH = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Code 2'd3 is unused; the controller treats it as IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN,
    ST_DONE = S_DONE
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Host-side handshake and operand/result bus of the serial adder.
// The host drives start/a/b; the controller drives busy/done/sum/carry.
interface serial_add_ctrl_if #(
  parameter int WIDTH = serial_add_ctrl_pkg::DEF_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;

  modport master (
    output start, a, b,
    input  busy, done, sum, carry
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, carry
  );

endinterface

// File: rtl/serial_add_ctrl_fa.sv
// Single-bit adder cell shared by the serial adder: a full adder built
// from two half adders, with the two partial carries ORed together.
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b;
  assign cout = a & b;

endmodule

module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic w_s1;
  logic w_c1;
  logic w_c2;

  half_adder u_ha0 (
    .a    (a),
    .b    (b),
    .sum  (w_s1),
    .cout (w_c1)
  );

  half_adder u_ha1 (
    .a    (w_s1),
    .b    (cin),
    .sum  (sum),
    .cout (w_c2)
  );

  // At most one of the partial carries can be set, so OR equals the majority.
  assign cout = w_c1 | w_c2;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller. Captures two WIDTH-bit operands on an
// accepted start, feeds one bit pair per cycle (LSB first) through a single
// full-adder cell, and publishes sum/carry with a one-cycle done pulse.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  serial_add_ctrl_if.slave bus
);

  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res_sh;
  logic [WIDTH-1:0] r_sum;
  logic             r_c;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;

  logic             w_s;
  logic             w_co;
  logic             w_accept;
  logic             w_last;

  // The one shared adder cell works on the current LSBs and the saved carry.
  full_adder_bit u_fa (
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .cin  (r_c),
    .sum  (w_s),
    .cout (w_co)
  );

  assign w_accept = (r_state == ST_IDLE) && bus.start;
  assign w_last   = (r_state == ST_RUN) && (r_cnt == CNT_LAST);

  // State register; reset dominates a simultaneous start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: IDLE -> RUN on start, RUN -> DONE after the last bit,
  // DONE -> IDLE unconditionally. Any unused code falls back to IDLE.
  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE: w_next = bus.start ? ST_RUN : ST_IDLE;
      ST_RUN:  w_next = (r_cnt == CNT_LAST) ? ST_DONE : ST_RUN;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Operand capture, per-bit shifting and carry/counter update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_c      <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a_sh   <= bus.a;
      r_b_sh   <= bus.b;
      r_res_sh <= '0;
      r_c      <= 1'b0;
      r_cnt    <= '0;
    end else if (r_state == ST_RUN) begin
      r_a_sh   <= r_a_sh >> 1;
      r_b_sh   <= r_b_sh >> 1;
      r_res_sh <= {w_s, r_res_sh[WIDTH-1:1]};
      r_c      <= w_co;
      // Hold on the last bit so the counter never has to represent WIDTH.
      if (!w_last) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Result registers: loaded only on the final RUN edge, held otherwise,
  // so they stay stable while the next addition is in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum   <= '0;
      r_carry <= 1'b0;
    end else if (w_last) begin
      r_sum   <= {w_s, r_res_sh[WIDTH-1:1]};
      r_carry <= w_co;
    end
  end

  assign bus.busy  = (r_state != ST_IDLE);
  assign bus.done  = (r_state == ST_DONE);
  assign bus.sum   = r_sum;
  assign bus.carry = r_carry;

endmodule
